// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int MULT_WIDTH_DEFAULT = 8;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int mult_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_abs.sv
// Combinational conditional two's-complement negate; used for operand
// magnitudes and for the final product sign fix-up.
module mult_abs #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    logic [WIDTH-1:0] w_one;

    assign w_one = {{(WIDTH-1){1'b0}}, 1'b1};
    assign o_val = i_neg ? (~i_val + w_one) : i_val;

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, one multiplier bit per clock, signed or
// unsigned, with valid/ready handshakes on input and output.
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 SIGNED,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P
);

    localparam int CW = mult_cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    mult_state_t          r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mpr;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_p;
    logic                 r_in_ready;
    logic                 r_out_valid;

    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_prod;

    assign w_neg_a = SIGNED & A[WIDTH-1];
    assign w_neg_b = SIGNED & B[WIDTH-1];

    // -2^(W-1) negates to itself, which read as unsigned is the right magnitude.
    mult_abs #(.WIDTH(WIDTH)) u_abs_a (
        .i_val (A),
        .i_neg (w_neg_a),
        .o_val (w_mag_a)
    );

    mult_abs #(.WIDTH(WIDTH)) u_abs_b (
        .i_val (B),
        .i_neg (w_neg_b),
        .o_val (w_mag_b)
    );

    assign w_addend   = r_mpr[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}};
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

    mult_abs #(.WIDTH(2*WIDTH)) u_abs_p (
        .i_val (w_acc_next),
        .i_neg (r_neg),
        .o_val (w_prod)
    );

    // FSM and datapath; all outputs come straight from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mcand     <= {WIDTH{1'b0}};
            r_mpr       <= {WIDTH{1'b0}};
            r_acc       <= {(2*WIDTH){1'b0}};
            r_cnt       <= {CW{1'b0}};
            r_neg       <= 1'b0;
            r_p         <= {(2*WIDTH){1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand    <= w_mag_a;
                        r_mpr      <= w_mag_b;
                        r_neg      <= w_neg_a ^ w_neg_b;
                        r_acc      <= {(2*WIDTH){1'b0}};
                        r_cnt      <= CNT_LOAD;
                        r_state    <= BUSY;
                        r_in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    r_acc <= w_acc_next;
                    r_mpr <= r_mpr >> 1;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state     <= DONE;
                        r_p         <= w_prod;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign P         = r_p;

endmodule

// File: doc/mult_seq.md
# mult_seq

Parametrised sequential shift-add multiplier that generalises the fixed 2-bit combinational `multiplier` to any operand width, with signed and unsigned modes and a valid/ready handshake on both sides. It is the next candidate in the multiplier design-space exploration. It sits behind the same stimulus-and-print benches, now driven through a handshake instead of fixed `#10` delays. It trades area for latency: one adder of width WIDTH, and one multiplier bit retired per clock.

## Interface
- `WIDTH`, default 8, is the operand width in bits. Legal range is 2 to 32.
- `clk`  input  1  is the only clock. All state changes on its rising edge.
- `rst`  input  1  is the reset: asynchronous, active-high.
- `in_valid`  input  1  means operands and mode are presented.
- `in_ready`  output  1  means the block can accept operands.
- `A`  input  WIDTH  is the multiplicand.
- `B`  input  WIDTH  is the multiplier.
- `SIGNED`  input  1  selects the mode: 1 means A and B are two's complement, 0 means unsigned. It is sampled together with A and B.
- `out_valid`  output  1  means P holds a finished product.
- `out_ready`  input  1  means the consumer takes P.
- `P`  output  2*WIDTH  is the product. It is two's complement when the sampled SIGNED was 1.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- IDLE:
  - `in_ready`=1.
  - When `in_valid`&&`in_ready`, the block latches |A| and |B| (the magnitude in signed mode, the raw value in unsigned mode).
  - It latches neg = SIGNED&(A[W-1]^B[W-1]), clears the accumulator, loads the counter with WIDTH, and moves to BUSY.
- BUSY, each cycle:
  - If the multiplier LSB is 1, add the multiplicand to the upper half of the accumulator.
  - Shift {carry, acc} right by 1 and decrement the counter.
  - When the counter reaches 1, move to DONE on that edge. On the same edge the final product is negated if neg=1.
- DONE:
  - `out_valid`=1 and P is held stable.
  - When `out_ready`=1, return to IDLE. `in_ready` rises the following cycle.
- There is no early termination. Every operation takes exactly WIDTH cycles in BUSY, including operands equal to 0.
- Width rules:
  - The accumulator is 2*WIDTH bits, plus a 1-bit carry on the add.
  - The magnitude of the most negative value (-2^(W-1)) is represented as an unsigned W-bit value.
  - Negation is two's complement over the full 2*WIDTH bits, so no product overflows.
- `in_valid` outside IDLE is ignored and is not queued. Operands change freely while BUSY.
- `out_ready` outside DONE is ignored.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, P=0, and internal registers at 0.
- If reset is asserted mid-operation (in BUSY or DONE), the operation is dropped. Outputs take their reset values immediately (asynchronously). The first accept is possible on the first rising edge after `rst` deasserts.
- Latency:
  - Operands are accepted at edge k.
  - `out_valid`=1 from edge k+WIDTH.
  - The result is held until the edge where `out_ready`=1. `out_valid` falls after that edge.
- Throughput: with `out_ready` held at 1, one product every WIDTH+2 cycles.
- P changes only on the BUSY→DONE edge and on reset. It keeps its last value in IDLE.
- `in_ready` and `out_valid` are never both 1.

## Structure
- Shared package `mult_pkg` holds:
  - the state enum `mult_state_t` (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - a default-width constant `MULT_WIDTH_DEFAULT`=8;
  - a function returning the counter width, $clog2(WIDTH+1).
- There is one natural sub-module, `mult_abs`: combinational conditional negate, parameterised by width. It is instantiated twice on the input side (operand magnitudes) and once on the output side (product sign fix-up, at 2*WIDTH).
- Everything else is in one always block for the FSM and datapath, with outputs driven from registers.

## Test plan
- WIDTH=2, unsigned. Run the existing pair list (2×2, 3×1, 1×1, 3×3, 2×3), each with `out_ready`=1. Expect P=4, 3, 1, 9, 6, with `out_valid` arriving exactly 2 cycles after each accept.
- WIDTH=8, unsigned:
  - 255×255 → P=65025 (16'hFE01).
  - 0×200 → P=0, still after 8 BUSY cycles.
- WIDTH=8, signed:
  - -128×-128 → P=16384.
  - -128×127 → P=-16256 (16'hC080).
  - -1×1 → P=16'hFFFF.
- Back-pressure:
  - Hold `out_ready`=0 for 5 cycles in DONE. P and `out_valid` must stay stable, and `in_ready` must stay 0.
  - Raise `out_ready`. `out_valid` must fall and `in_ready` must rise on the next cycle.
- Ignored input: toggle `in_valid` and change A and B during BUSY. The result must equal the product of the operands latched at accept.
- Reset: assert `rst` 3 cycles into BUSY. `out_valid`=0, `in_ready`=1 and P=0 must hold immediately. A new operation, 7×6, must then complete normally with P=42.
